// File: rtl/cpi_pattern_tx.sv
// cpi_pattern_tx: camera (CPI) pattern source.
// It generates a pixel clock, vsync, hsync and an 8-bit test pattern so that
// the on-chip camera receiver can be exercised without a real sensor.
// All frame outputs change on the system-clock edge where pclk falls. They
// stay stable across the following pclk rising edge, where the receiver samples.
module cpi_pattern_tx #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned VSYNC_TICKS = 4,
    parameter int unsigned VBP_TICKS   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [15:0] cfg_width_i,
    input  logic [15:0] cfg_height_i,
    input  logic [7:0]  cfg_hblank_i,
    input  logic [1:0]  cfg_pattern_i,
    output logic        cam_pclk_o,
    output logic        cam_vsync_o,
    output logic        cam_hsync_o,
    output logic [7:0]  cam_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned    DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [15:0]      VS_LAST  = 16'(VSYNC_TICKS - 1);
    localparam logic [15:0]      VBP_LAST = 16'(VBP_TICKS - 1);

    // The end-of-frame step takes no time, so it has no state of its own.
    // It is carried out on the exit edge of the last HBLANK.
    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_LINE,
        S_HBLANK
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             tick;
    logic [15:0]      cnt;
    logic [15:0]      col;
    logic [15:0]      row;
    logic [15:0]      w_q;
    logic [15:0]      h_q;
    logic [7:0]       hb_q;
    logic [1:0]       pat_q;
    logic [15:0]      w_eff;
    logic [15:0]      h_eff;
    logic [7:0]       hb_eff;

    // Pixel byte for a given pattern, column, row and frame count.
    function automatic logic [7:0] pixel(input logic [1:0]  pat,
                                         input logic [15:0] c,
                                         input logic [15:0] r,
                                         input logic [15:0] fcnt);
        logic [7:0] p;
        case (pat)
            2'd0:    p = c[7:0];
            2'd1:    p = r[7:0];
            2'd2:    p = (c[3] ^ r[3]) ? 8'hFF : 8'h00;
            default: p = c[7:0] + fcnt[7:0];
        endcase
        return p;
    endfunction

    // Divider next value, the tick strobe, and zero-size configuration mapped to 1.
    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        div_next = tick ? '0 : div_cnt + 1'b1;
        w_eff    = (cfg_width_i  == '0) ? 16'd1 : cfg_width_i;
        h_eff    = (cfg_height_i == '0) ? 16'd1 : cfg_height_i;
        hb_eff   = (cfg_hblank_i == '0) ? 8'd1  : cfg_hblank_i;
    end

    // Free-running pixel-clock divider. pclk is low for the first half of each period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt    <= '0;
            cam_pclk_o <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            cam_pclk_o <= (div_next >= DIV_HALF);
        end
    end

    // Frame sequencer with registered sync, data and status outputs. It advances only on ticks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            cnt          <= '0;
            col          <= '0;
            row          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            hb_q         <= '0;
            pat_q        <= '0;
            cam_vsync_o  <= 1'b0;
            cam_hsync_o  <= 1'b0;
            cam_data_o   <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            frame_done_o <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (en_i) begin
                            state       <= S_VSYNC;
                            cnt         <= '0;
                            cam_vsync_o <= 1'b1;
                            busy_o      <= 1'b1;
                            w_q         <= w_eff;
                            h_q         <= h_eff;
                            hb_q        <= hb_eff;
                            pat_q       <= cfg_pattern_i;
                        end
                    end
                    S_VSYNC: begin
                        if (cnt == VS_LAST) begin
                            cnt         <= '0;
                            cam_vsync_o <= 1'b0;
                            if (VBP_TICKS == 0) begin
                                state       <= S_LINE;
                                col         <= '0;
                                row         <= '0;
                                cam_hsync_o <= 1'b1;
                                cam_data_o  <= pixel(pat_q, 16'd0, 16'd0, frame_cnt_o);
                            end else begin
                                state <= S_VBP;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_VBP: begin
                        if (cnt == VBP_LAST) begin
                            state       <= S_LINE;
                            cnt         <= '0;
                            col         <= '0;
                            row         <= '0;
                            cam_hsync_o <= 1'b1;
                            cam_data_o  <= pixel(pat_q, 16'd0, 16'd0, frame_cnt_o);
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_LINE: begin
                        if (col == w_q - 16'd1) begin
                            state       <= S_HBLANK;
                            cnt         <= '0;
                            cam_hsync_o <= 1'b0;
                            cam_data_o  <= '0;
                        end else begin
                            col        <= col + 16'd1;
                            cam_data_o <= pixel(pat_q, col + 16'd1, row, frame_cnt_o);
                        end
                    end
                    S_HBLANK: begin
                        if (cnt == {8'h00, hb_q - 8'd1}) begin
                            cnt <= '0;
                            if (row != h_q - 16'd1) begin
                                state       <= S_LINE;
                                col         <= '0;
                                row         <= row + 16'd1;
                                cam_hsync_o <= 1'b1;
                                cam_data_o  <= pixel(pat_q, 16'd0, row + 16'd1, frame_cnt_o);
                            end else begin
                                frame_done_o <= 1'b1;
                                frame_cnt_o  <= frame_cnt_o + 16'd1;
                                if (en_i) begin
                                    state       <= S_VSYNC;
                                    cam_vsync_o <= 1'b1;
                                    w_q         <= w_eff;
                                    h_q         <= h_eff;
                                    hb_q        <= hb_eff;
                                    pat_q       <= cfg_pattern_i;
                                end else begin
                                    state  <= S_IDLE;
                                    busy_o <= 1'b0;
                                end
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        cam_vsync_o <= 1'b0;
                        cam_hsync_o <= 1'b0;
                        cam_data_o  <= '0;
                        busy_o      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpi_pattern_tx.sv
// tb_cpi_pattern_tx: frame-level reference checks for cpi_pattern_tx.
module tb_cpi_pattern_tx;

    localparam int CLK_DIV     = 4;
    localparam int VSYNC_TICKS = 4;
    localparam int VBP_TICKS   = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] cfg_width_i = '0;
    logic [15:0] cfg_height_i = '0;
    logic [7:0]  cfg_hblank_i = '0;
    logic [1:0]  cfg_pattern_i = '0;
    logic        cam_pclk_o;
    logic        cam_vsync_o;
    logic        cam_hsync_o;
    logic [7:0]  cam_data_o;
    logic        busy_o;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;

    always #5 clk_i = ~clk_i;

    cpi_pattern_tx #(
        .CLK_DIV    (CLK_DIV),
        .VSYNC_TICKS(VSYNC_TICKS),
        .VBP_TICKS  (VBP_TICKS)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .cfg_hblank_i (cfg_hblank_i),
        .cfg_pattern_i(cfg_pattern_i),
        .cam_pclk_o   (cam_pclk_o),
        .cam_vsync_o  (cam_vsync_o),
        .cam_hsync_o  (cam_hsync_o),
        .cam_data_o   (cam_data_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_fc = 0;

    // Samples are stored as {vsync, hsync, data}, one per pclk rising edge.
    logic [9:0] cap_q[$];
    logic [9:0] exp_q[$];
    int done_seen;
    int busy_cyc;
    int vs_cyc;
    int exp_ticks;
    bit timed_out;

    function automatic logic [7:0] ref_pixel(input int pat, input int c, input int r, input int fc);
        case (pat)
            0:       return 8'(c % 256);
            1:       return 8'(r % 256);
            2:       return (((c / 8) % 2) != ((r / 8) % 2)) ? 8'hFF : 8'h00;
            default: return 8'((c + fc) % 256);
        endcase
    endfunction

    // Reference receiver view of n consecutive frames, starting at frame count model_fc.
    task automatic build_expected(input int w, input int h, input int hb, input int pat, input int nframes);
        int we = (w == 0) ? 1 : w;
        int he = (h == 0) ? 1 : h;
        int hbe = (hb == 0) ? 1 : hb;
        exp_q.delete();
        exp_ticks = 0;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < VSYNC_TICKS; i++) exp_q.push_back(10'h200);
            for (int i = 0; i < VBP_TICKS; i++) exp_q.push_back(10'h000);
            for (int r = 0; r < he; r++) begin
                for (int c = 0; c < we; c++)
                    exp_q.push_back({2'b01, ref_pixel(pat, c, r, (model_fc + f) % 65536)});
                for (int i = 0; i < hbe; i++) exp_q.push_back(10'h000);
            end
            exp_ticks += VSYNC_TICKS + VBP_TICKS + he * (we + hbe);
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int hb, input int pat);
        cfg_width_i   = 16'(w);
        cfg_height_i  = 16'(h);
        cfg_hblank_i  = 8'(hb);
        cfg_pattern_i = 2'(pat);
    endtask

    // Enable the source, record pclk-rise samples until it returns to idle.
    // Keep en_i high until the last requested frame has started.
    task automatic capture(input int nframes, input bit scramble, input int budget);
        int  cyc = 0;
        bit  started = 0;
        logic prev_pclk;
        cap_q.delete();
        done_seen = 0;
        busy_cyc  = 0;
        vs_cyc    = 0;
        timed_out = 0;
        en_i      = 1'b1;
        prev_pclk = cam_pclk_o;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (busy_o) begin
                started = 1;
                busy_cyc++;
            end
            if (cam_vsync_o) vs_cyc++;
            if (frame_done_o) done_seen++;
            if (started && cam_pclk_o && !prev_pclk)
                cap_q.push_back({cam_vsync_o, cam_hsync_o, cam_data_o});
            prev_pclk = cam_pclk_o;
            if (started && done_seen >= nframes - 1) en_i = 1'b0;
            if (scramble && cam_hsync_o)
                set_cfg($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 9), $urandom_range(0, 3));
            if (started && !busy_o) break;
            if (cyc > budget) begin
                timed_out = 1;
                en_i = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int highs = 0;
        rst_ni = 1'b0;
        en_i = 1'b1;
        set_cfg($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 4), $urandom_range(0, 3));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({cam_pclk_o, cam_vsync_o, cam_hsync_o, cam_data_o, busy_o, frame_done_o, frame_cnt_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got pclk=%b vs=%b hs=%b d=%h busy=%b done=%b fc=%h, expected all 0",
                         cam_pclk_o, cam_vsync_o, cam_hsync_o, cam_data_o, busy_o, frame_done_o, frame_cnt_o);
            end
        end
        en_i = 1'b0;
        rst_ni = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk_i);
            if (cam_pclk_o) highs++;
            n_checks++;
            if (cam_pclk_o !== ((n % CLK_DIV) >= CLK_DIV / 2)) begin
                n_fail++;
                $display("FAIL pclk_phase: edge %0d got %b expected %b", n, cam_pclk_o, ((n % CLK_DIV) >= CLK_DIV / 2));
            end
        end
        n_checks++;
        if (highs !== 8) begin
            n_fail++;
            $display("FAIL pclk_duty: got %0d high cycles expected 8", highs);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy_o);
        end
    endtask

    task automatic test_single_frame;
        set_cfg(4, 2, 2, 0);
        build_expected(4, 2, 2, 0, 1);
        capture(1, 0, exp_ticks * CLK_DIV + 64);
        model_fc += 1;
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL single_timeout: got timeout expected idle"); end
        n_checks++;
        if (cap_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single_len: got %0d samples expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (vs_cyc !== VSYNC_TICKS * CLK_DIV) begin n_fail++; $display("FAIL single_vsync_clks: got %0d expected 16", vs_cyc); end
        n_checks++;
        if (busy_cyc !== 72) begin n_fail++; $display("FAIL single_active_clks: got %0d expected 72", busy_cyc); end
        n_checks++;
        if (done_seen !== 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", done_seen); end
        n_checks++;
        if (frame_cnt_o !== 16'(model_fc)) begin n_fail++; $display("FAIL single_cnt: got %0d expected %0d", frame_cnt_o, model_fc); end
    endtask

    task automatic test_row_ramp;
        int hb = $urandom_range(1, 3);
        set_cfg(2, 3, hb, 1);
        build_expected(2, 3, hb, 1, 1);
        capture(1, 0, exp_ticks * CLK_DIV + 64);
        model_fc += 1;
        n_checks++;
        if (timed_out || cap_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL row_len: got %0d samples (timeout=%b) expected %0d", cap_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL row_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (frame_cnt_o !== 16'(model_fc)) begin n_fail++; $display("FAIL row_cnt: got %0d expected %0d", frame_cnt_o, model_fc); end
    endtask

    task automatic test_back_to_back;
        set_cfg(3, 1, 2, 3);
        build_expected(3, 1, 2, 3, 2);
        capture(2, 0, exp_ticks * CLK_DIV + 64);
        model_fc += 2;
        n_checks++;
        if (timed_out || cap_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_len: got %0d samples (timeout=%b) expected %0d", cap_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (busy_cyc !== exp_ticks * CLK_DIV) begin n_fail++; $display("FAIL b2b_active_clks: got %0d expected %0d", busy_cyc, exp_ticks * CLK_DIV); end
        n_checks++;
        if (done_seen !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d expected 2", done_seen); end
        n_checks++;
        if (frame_cnt_o !== 16'(model_fc)) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", frame_cnt_o, model_fc); end
    endtask

    task automatic test_degenerate_cfg;
        int pat = $urandom_range(0, 3);
        set_cfg(0, 0, 0, pat);
        build_expected(0, 0, 0, pat, 1);
        capture(1, 1, exp_ticks * CLK_DIV + 64);
        model_fc += 1;
        n_checks++;
        if (timed_out || cap_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL degen_len: got %0d samples (timeout=%b) expected %0d", cap_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL degen_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (busy_cyc !== exp_ticks * CLK_DIV) begin n_fail++; $display("FAIL degen_active_clks: got %0d expected %0d", busy_cyc, exp_ticks * CLK_DIV); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            int w = $urandom_range(0, 20);
            int h = $urandom_range(0, 12);
            int hb = $urandom_range(0, 6);
            int pat = $urandom_range(0, 3);
            int nf = $urandom_range(1, 2);
            set_cfg(w, h, hb, pat);
            build_expected(w, h, hb, pat, nf);
            capture(nf, 0, exp_ticks * CLK_DIV + 64);
            model_fc += nf;
            n_checks++;
            if (timed_out || cap_q.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL rand_len: it %0d got %0d samples (timeout=%b) expected %0d", it, cap_q.size(), timed_out, exp_q.size());
            end
            for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (cap_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_sample[%0d]: it %0d got %h expected %h", i, it, cap_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (done_seen !== nf || frame_cnt_o !== 16'(model_fc)) begin
                n_fail++; $display("FAIL rand_frames: got done=%0d cnt=%0d expected done=%0d cnt=%0d", done_seen, frame_cnt_o, nf, model_fc);
            end
        end
    endtask

    task automatic test_reset_mid_line;
        int  pat = $urandom_range(0, 3);
        bit  seen = 0;
        set_cfg(8, 4, 2, pat);
        en_i = 1'b1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_i);
            if (cam_hsync_o) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL midline_wait: got no hsync expected hsync within 400 clks"); end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({cam_pclk_o, cam_vsync_o, cam_hsync_o, cam_data_o, busy_o, frame_done_o, frame_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL midline_async_reset: got vs=%b hs=%b d=%h busy=%b fc=%h expected all 0",
                     cam_vsync_o, cam_hsync_o, cam_data_o, busy_o, frame_cnt_o);
        end
        en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        model_fc = 0;
        build_expected(8, 4, 2, pat, 1);
        capture(1, 0, exp_ticks * CLK_DIV + 64);
        model_fc += 1;
        n_checks++;
        if (timed_out || cap_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL restart_len: got %0d samples (timeout=%b) expected %0d", cap_q.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL restart_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (frame_cnt_o !== 16'(model_fc)) begin n_fail++; $display("FAIL restart_cnt: got %0d expected %0d", frame_cnt_o, model_fc); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_row_ramp();
        test_back_to_back();
        test_degenerate_cfg();
        test_random();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
